// File: rtl/tx_serial_pkg.sv
// Shared serial-link definitions: FSM state encoding and frame length.
// The receiver side imports the same package so both ends agree on framing.
package tx_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } tx_state_t;

    // start + data + parity + stop
    function automatic int frame_len(input int n_bits);
        return n_bits + 3;
    endfunction

endpackage

// File: rtl/tx_serial_baud_tick_gen.sv
// Bit-period timer: one-cycle tick every CLK_P_BIT enabled cycles.
// Dropping enable clears the count so each frame starts with a full period.
module baud_tick_gen #(
    parameter int CLK_P_BIT = 5208
) (
    input  logic clock,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_P_BIT > 1) ? $clog2(CLK_P_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_P_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (!en || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/tx_serial.sv
// Asynchronous serial transmitter: start, N_BITS data (LSB first), parity, stop.
// txd and fim come straight from flops so the line never glitches.
module tx_serial
    import tx_serial_pkg::*;
#(
    parameter int BAUD_RATE = 9600,
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int N_BITS    = 8,
    parameter int PARITY    = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              partida,
    input  logic [N_BITS-1:0] dados,
    output logic              txd,
    output logic              ocupado,
    output logic              fim
);

    localparam int CLK_P_BIT = CLOCK_HZ / BAUD_RATE;
    localparam int BW        = $clog2(N_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(N_BITS - 1);

    tx_state_t         state, state_nxt;
    logic [BW-1:0]     bit_idx, bit_nxt;
    logic [N_BITS-1:0] data_q, data_nxt, data_shift;
    logic              par_q, par_nxt;
    logic              txd_nxt, fim_nxt;
    logic              baud_en, tick;

    assign baud_en    = (state == ST_START) || (state == ST_DATA) ||
                        (state == ST_PAR)   || (state == ST_STOP);
    assign data_shift = data_q >> 1;
    assign ocupado    = (state != ST_IDLE);

    baud_tick_gen #(.CLK_P_BIT(CLK_P_BIT)) u_baud (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (baud_en),
        .tick    (tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            txd     <= 1'b1;
            fim     <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_idx <= bit_nxt;
            data_q  <= data_nxt;
            par_q   <= par_nxt;
            txd     <= txd_nxt;
            fim     <= fim_nxt;
        end
    end

    // Next-state logic also computes the value txd holds for the coming bit.
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_idx;
        data_nxt  = data_q;
        par_nxt   = par_q;
        txd_nxt   = txd;
        fim_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                txd_nxt = 1'b1;
                if (partida) begin
                    data_nxt  = dados;
                    par_nxt   = (PARITY != 0) ? ~^dados : ^dados;
                    bit_nxt   = '0;
                    txd_nxt   = 1'b0;
                    state_nxt = ST_START;
                end
            end
            ST_START: if (tick) begin
                txd_nxt   = data_q[0];
                state_nxt = ST_DATA;
            end
            ST_DATA: if (tick) begin
                if (bit_idx == LAST_BIT) begin
                    txd_nxt   = par_q;
                    state_nxt = ST_PAR;
                end else begin
                    bit_nxt  = bit_idx + 1'b1;
                    data_nxt = data_shift;
                    txd_nxt  = data_shift[0];
                end
            end
            ST_PAR: if (tick) begin
                txd_nxt   = 1'b1;
                state_nxt = ST_STOP;
            end
            ST_STOP: if (tick) begin
                fim_nxt   = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                txd_nxt   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                txd_nxt   = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_serial.sv
// Bench for tx_serial: odd- and even-parity instances share stimulus, and every
// cycle of each frame is compared against a frame image built from the data word.
module tb_tx_serial;

    localparam int BAUD = 10;
    localparam int CHZ  = 80;
    localparam int NB   = 8;
    localparam int P    = CHZ / BAUD;
    localparam int NF   = NB + 3;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          partida = 1'b0;
    logic [NB-1:0] dados   = '0;
    logic          txd_o, oc_o, fim_o;
    logic          txd_e, oc_e, fim_e;
    int            n_pass  = 0;
    int            n_chk   = 0;
    logic [NB-1:0] d, d2;

    always #5 clock = ~clock;

    tx_serial #(.BAUD_RATE(BAUD), .CLOCK_HZ(CHZ), .N_BITS(NB), .PARITY(1)) u_odd (
        .clock(clock), .reset_n(reset_n), .partida(partida), .dados(dados),
        .txd(txd_o), .ocupado(oc_o), .fim(fim_o));

    tx_serial #(.BAUD_RATE(BAUD), .CLOCK_HZ(CHZ), .N_BITS(NB), .PARITY(0)) u_even (
        .clock(clock), .reset_n(reset_n), .partida(partida), .dados(dados),
        .txd(txd_e), .ocupado(oc_e), .fim(fim_e));

    // Line image, slot 0 first: start, data LSB first, parity, stop.
    function automatic logic [NF-1:0] frame(input logic [NB-1:0] w, input bit odd);
        int   ones;
        logic pb;
        ones = $countones(w);
        pb   = odd ? (ones % 2 == 0) : (ones % 2 == 1);
        return {1'b1, pb, w, 1'b0};
    endfunction

    task automatic chk(input string tag, input int cyc, input logic [2:0] obs, input logic [2:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d {txd,ocupado,fim} got=%b want=%b", tag, cyc, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_odd"},  -1, {txd_o, oc_o, fim_o}, 3'b100);
        chk({tag, "_even"}, -1, {txd_e, oc_e, fim_e}, 3'b100);
    endtask

    // Caller has partida=1 and dados=w set before the acceptance edge.
    task automatic run_frame(input logic [NB-1:0] w, input bit hold, input int pulse_at);
        logic [NF-1:0] fo, fe;
        fo = frame(w, 1'b1);
        fe = frame(w, 1'b0);
        @(posedge clock);
        for (int i = 0; i <= NF * P; i++) begin
            @(negedge clock);
            if (i < NF * P) begin
                chk("odd",  i, {txd_o, oc_o, fim_o}, {fo[i / P], 2'b10});
                chk("even", i, {txd_e, oc_e, fim_e}, {fe[i / P], 2'b10});
            end else begin
                chk("odd_done",  i, {txd_o, oc_o, fim_o}, 3'b111);
                chk("even_done", i, {txd_e, oc_e, fim_e}, 3'b111);
            end
            dados = NB'($urandom);
            if (!hold) partida = (i == pulse_at);
        end
    endtask

    initial begin
        #12;
        chk_idle("reset");

        // first request right after reset release, "V"
        @(negedge clock);
        reset_n = 1'b1;
        partida = 1'b1;
        dados   = 8'h56;
        run_frame(8'h56, 1'b0, -1);
        repeat (3) begin
            @(negedge clock);
            chk_idle("idle_after_v");
        end

        // "{" : parity 1 on the odd instance, 0 on the even one
        @(negedge clock);
        partida = 1'b1;
        dados   = 8'h7B;
        run_frame(8'h7B, 1'b0, -1);
        @(negedge clock);
        chk_idle("idle_after_brace");

        // stray partida in the middle of DATA
        d = NB'($urandom);
        @(negedge clock);
        partida = 1'b1;
        dados   = d;
        run_frame(d, 1'b0, 5 * P);
        @(negedge clock);
        chk_idle("idle_after_stray");

        // partida held high: two frames, one idle cycle between them
        d  = NB'($urandom);
        d2 = NB'($urandom);
        @(negedge clock);
        partida = 1'b1;
        dados   = d;
        run_frame(d, 1'b1, -1);
        @(negedge clock);
        chk_idle("b2b_gap");
        dados = d2;
        run_frame(d2, 1'b1, -1);
        partida = 1'b0;
        @(negedge clock);
        chk_idle("b2b_end");

        repeat (4) begin
            d = NB'($urandom);
            @(negedge clock);
            partida = 1'b1;
            dados   = d;
            run_frame(d, 1'b0, -1);
        end

        // reset in the middle of frame slot 3
        d = NB'($urandom);
        @(negedge clock);
        partida = 1'b1;
        dados   = d;
        @(posedge clock);
        for (int i = 0; i < 3 * P + P / 2; i++) begin
            @(negedge clock);
            partida = 1'b0;
            if (i == 3 * P + 1)
                chk("pre_abort", i, {txd_o, oc_o, fim_o}, {frame(d, 1'b1) >> 3, 2'b10} & 3'b110);
        end
        reset_n = 1'b0;
        #1;
        chk_idle("abort");
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clock);
            chk_idle("abort_hold");
        end
        d2 = NB'($urandom);
        reset_n = 1'b1;
        partida = 1'b1;
        dados   = d2;
        run_frame(d2, 1'b0, -1);
        @(negedge clock);
        chk_idle("after_abort");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
